// File: rtl/bootrom_loader.sv
// Boot-time copy sequencer: copies COPY_WORDS words from the synchronous boot ROM into RAM,
// holding the core in reset until the copy is done. Optional BOOTROM_LOADER_CHECKSUM_EN adds a sum.
module bootrom_loader #(
    parameter int unsigned COPY_WORDS = 8192,
    parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
    parameter logic [31:0] DST_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rd_data,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wr_data,
    input  logic        ram_ready,
    input  logic        reload,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    // A zero-word copy still needs a legal one-bit counter.
    localparam int unsigned IDX_W = (COPY_WORDS == 0) ? 1 : $clog2(COPY_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = (COPY_WORDS == 0) ? '0 : IDX_W'(COPY_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      byte_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                state_d = (COPY_WORDS == 0) ? StDone : StRead;
            end
            StRead: begin
                state_d = StWrite;
            end
            StWrite: begin
                if (ram_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        state_d = StRead;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            StDone: begin
                if (reload) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // ROM address is held through WRITE so its registered data stays stable during stalls.
    assign byte_off = 32'(idx_q) << 2;

    always_comb begin
        rom_addr    = SRC_BASE + byte_off;
        ram_addr    = DST_BASE + byte_off;
        ram_we      = (state_q == StWrite);
        ram_wr_data = (state_q == StWrite) ? rom_rd_data : 32'h0;
        cpu_rst     = (state_q != StDone);
        busy        = (state_q == StRead) || (state_q == StWrite);
        done        = (state_q == StDone);
    end

`ifdef BOOTROM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= 32'h0;
        end else if ((state_q == StIdle) && (state_d == StRead)) begin
            checksum_q <= 32'h0;
        end else if (ram_we && ram_ready) begin
            checksum_q <= checksum_q + ram_wr_data;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_bootrom_loader.sv
// Self-checking bench for bootrom_loader: three instances (4 words, 0 words, 6 words with a
// wrapping RAM base) checked every cycle against a word-count/cycle-count model.
module tb_bootrom_loader;

    localparam int ND = 3;
    localparam int unsigned NW  [ND] = '{4, 0, 6};
    localparam logic [31:0] SRC [ND] = '{32'h0000_0000, 32'h0000_0040, 32'h0000_1000};
    localparam logic [31:0] DST [ND] = '{32'h0000_0000, 32'h0000_2000, 32'hFFFF_FFF0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reload = 1'b0;
    logic        ready       [ND];
    logic [31:0] rom_addr    [ND];
    logic [31:0] rom_q       [ND];
    logic [31:0] ram_addr    [ND];
    logic [31:0] ram_wr_data [ND];
    logic        ram_we      [ND];
    logic        cpu_rst     [ND];
    logic        busy        [ND];
    logic        done        [ND];
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    logic [31:0] checksum    [ND];
`endif
    logic [31:0] rom_mem     [ND][8];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        bootrom_loader #(
            .COPY_WORDS(NW[g]),
            .SRC_BASE  (SRC[g]),
            .DST_BASE  (DST[g])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .rom_addr   (rom_addr[g]),
            .rom_rd_data(rom_q[g]),
            .ram_we     (ram_we[g]),
            .ram_addr   (ram_addr[g]),
            .ram_wr_data(ram_wr_data[g]),
            .ram_ready  (ready[g]),
            .reload     (reload),
            .cpu_rst    (cpu_rst[g]),
            .busy       (busy[g]),
            .done       (done[g])
`ifdef BOOTROM_LOADER_CHECKSUM_EN
            ,
            .checksum   (checksum[g])
`endif
        );
    end

    always #5 clk = ~clk;

    // Synchronous-read ROM: one cycle from address to data.
    always @(posedge clk) begin
        for (int i = 0; i < ND; i++) begin
            rom_q[i] <= rom_mem[i][((rom_addr[i] - SRC[i]) >> 2) & 32'h7];
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got 0x%08h want 0x%08h", name, i, act, exp);
        end
    endtask

    // Model: words accepted so far, stall cycles seen, cycle index since the copy began.
    int          ph         [ND];
    int          acc        [ND];
    int          stalls     [ND];
    int          done_ph    [ND];
    int          done_rises [ND];
    int          we_cycles  [ND];
    bit          mdone      [ND];
    bit          started    [ND];
    bit          restart_nx [ND];
    bit          seen_done  [ND];
    bit          prev_rst = 1'b0;
    int          wr_ph      [8];
    int          wr_n0;
    int          target;
    logic [31:0] csum_tmp;

    initial begin
        for (int i = 0; i < ND; i++) begin
            started[i] = 1'b0; restart_nx[i] = 1'b0; mdone[i] = 1'b0;
            done_rises[i] = 0; we_cycles[i] = 0; done_ph[i] = -1; ph[i] = 0;
        end
        wr_n0 = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (prev_rst || restart_nx[i]) begin
                ph[i] = 0; acc[i] = 0; stalls[i] = 0; mdone[i] = 1'b0;
                started[i] = 1'b1; restart_nx[i] = 1'b0; seen_done[i] = 1'b0;
                if (i == 0) wr_n0 = 0;
            end
            if (started[i]) begin
                check("cpu_rst_is_not_done", i, 32'(cpu_rst[i]), 32'(!done[i]));
                if (done[i] && !seen_done[i]) begin
                    seen_done[i] = 1'b1;
                    done_ph[i] = ph[i];
                    done_rises[i]++;
                end
                if (prev_rst && rst) begin
                    check("rst_rom_addr", i, rom_addr[i], SRC[i]);
                    check("rst_ram_addr", i, ram_addr[i], DST[i]);
                    check("rst_wr_data", i, ram_wr_data[i], 32'h0);
                    check("rst_busy", i, 32'(busy[i]), 32'h0);
`ifdef BOOTROM_LOADER_CHECKSUM_EN
                    check("rst_checksum", i, checksum[i], 32'h0);
`endif
                end
                target = 1 + 2 * int'(NW[i]) + stalls[i];
                if (mdone[i] || ph[i] == target) begin
                    check("done", i, 32'(done[i]), 32'h1);
                    check("busy_in_done", i, 32'(busy[i]), 32'h0);
                    check("we_in_done", i, 32'(ram_we[i]), 32'h0);
                    if (!mdone[i]) begin
                        check("words_written", i, acc[i], NW[i]);
`ifdef BOOTROM_LOADER_CHECKSUM_EN
                        csum_tmp = 32'h0;
                        for (int k = 0; k < int'(NW[i]); k++) csum_tmp += rom_mem[i][k];
                        check("checksum", i, checksum[i], csum_tmp);
`endif
                    end
                    mdone[i] = 1'b1;
                    if (reload) restart_nx[i] = 1'b1;
                end else begin
                    check("not_done", i, 32'(done[i]), 32'h0);
                    check("busy", i, 32'(busy[i]), 32'(ph[i] != 0));
                    if (ph[i] == 0) begin
                        check("idle_we", i, 32'(ram_we[i]), 32'h0);
                        check("idle_rom_addr", i, rom_addr[i], SRC[i]);
                        check("idle_ram_addr", i, ram_addr[i], DST[i]);
                    end else begin
                        check("rom_addr", i, rom_addr[i], SRC[i] + 32'(4 * acc[i]));
                    end
                    if (ram_we[i]) begin
                        we_cycles[i]++;
                        check("write_in_range", i, 32'(acc[i] < int'(NW[i])), 32'h1);
                        check("ram_addr", i, ram_addr[i], DST[i] + 32'(4 * acc[i]));
                        check("ram_wr_data", i, ram_wr_data[i], rom_mem[i][acc[i] % 8]);
                        if (ready[i]) begin
                            if (i == 0) begin
                                if (wr_n0 < 8) wr_ph[wr_n0] = ph[i];
                                wr_n0++;
                            end
                            acc[i]++;
                        end else begin
                            stalls[i]++;
                        end
                    end
                end
                ph[i]++;
            end
        end
        prev_rst = rst;
    end

    function automatic bit all_done();
        return mdone[0] && mdone[1] && mdone[2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_all_done(input string name);
        int n = 0;
        while (!all_done() && n < 300) begin
            tick();
            n++;
        end
        check(name, 0, 32'(all_done()), 32'h1);
    endtask

    task automatic wait_ph(input int p);
        int n = 0;
        while (ph[0] != p && n < 100) begin
            tick();
            n++;
        end
        check("reach_phase", 0, ph[0], p);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("cpu_rst_after_reload", 0, 32'(cpu_rst[0]), 32'h1);
        tick();
    endtask

    int r0;
    int quiet;
    int n;

    initial begin
        for (int i = 0; i < ND; i++) begin
            ready[i] = 1'b1;
            for (int k = 0; k < 8; k++) rom_mem[i][k] = $urandom;
        end
        rom_mem[0][0] = 32'd11; rom_mem[0][1] = 32'd22;
        rom_mem[0][2] = 32'd33; rom_mem[0][3] = 32'd44;

        // Plain copy, ready tied high.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        wait_all_done("copy1_finished");
        check("lit_done_cycle4", 0, done_ph[0], 9);
        for (int k = 0; k < 4; k++) check("lit_write_cycle", 0, wr_ph[k], 2 + 2 * k);
        check("lit_done_cycle0", 1, done_ph[1], 1);
        check("lit_done_cycle6", 2, done_ph[2], 13);
`ifdef BOOTROM_LOADER_CHECKSUM_EN
        check("lit_checksum", 0, checksum[0], 32'd110);
`endif

        // Three-cycle stall on word 1.
        pulse_reload();
        wait_ph(4);
        ready[0] = 1'b0;
        repeat (3) tick();
        ready[0] = 1'b1;
        wait_all_done("stall_finished");
        check("lit_stall_done", 0, done_ph[0], 12);
        check("lit_stall_writes", 0, wr_n0, 4);
        check("lit_stall_word1", 0, wr_ph[1], 7);
        check("lit_stall_word3", 0, wr_ph[3], 11);
`ifdef BOOTROM_LOADER_CHECKSUM_EN
        check("lit_checksum_reload", 0, checksum[0], 32'd110);
`endif

        // Reload while busy is ignored; reset mid-write of word 2 restarts once.
        pulse_reload();
        r0 = done_rises[0];
        wait_ph(3);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        wait_ph(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_all_done("restart_finished");
        check("lit_restart_done", 0, done_ph[0], 9);
        check("lit_done_once", 0, done_rises[0] - r0, 1);
        check("lit_restart_writes", 0, wr_n0, 4);
        check("lit_zero_never_writes", 1, we_cycles[1], 0);

        // Randomized backpressure, reload-while-busy and reset.
        repeat (6) begin
            pulse_reload();
            n = 0;
            quiet = 0;
            while (n < 600 && !(all_done() && quiet >= 3)) begin
                for (int i = 0; i < ND; i++) ready[i] = ($urandom_range(0, 3) != 0);
                rst = ($urandom_range(0, 79) == 0);
                reload = busy[0] && ($urandom_range(0, 7) == 0);
                if (rst || reload) quiet = 0;
                else quiet++;
                tick();
                n++;
            end
            rst = 1'b0;
            reload = 1'b0;
            for (int i = 0; i < ND; i++) ready[i] = 1'b1;
            check("random_copy_finished", 0, 32'(all_done()), 32'h1);
        end
        check("lit_zero_never_writes_end", 1, we_cycles[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bootrom_loader.md
Name: bootrom_loader

Overview:
- Boot-time copy sequencer between the synchronous-read boot ROM and the instruction/data RAM.
- After reset, it copies COPY_WORDS 32-bit words from the boot ROM into RAM and holds the core in reset during the copy.
- When the copy completes it releases the core and stays idle until a reload request.
- It accounts for the ROM's one-cycle registered-address read latency and for RAM write backpressure.

Parameters:
- COPY_WORDS, 8192: number of 32-bit words to copy. Range 0..8192.
- SRC_BASE, 32'h0000_0000: byte address of the first ROM word.
- DST_BASE, 32'h0000_0000: byte address of the first RAM word.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rom_addr  output  32  ROM byte address; the ROM registers it on the rising edge of clk
- rom_rd_data  input  32  ROM read data; valid one cycle after rom_addr is sampled
- ram_we  output  1  RAM write strobe
- ram_addr  output  32  RAM byte address
- ram_wr_data  output  32  RAM write data
- ram_ready  input  1  RAM accepts the write on a clk edge where ram_we=1 and ram_ready=1
- reload  input  1  single-cycle request to repeat the copy; honoured only in DONE
- cpu_rst  output  1  core reset hold; 1 while not in DONE
- busy  output  1  1 in READ or WRITE
- done  output  1  1 in DONE

Behaviour:
- Reset values:
  - state=IDLE, idx=0, ram_we=0, cpu_rst=1, busy=0, done=0.
  - rom_addr=SRC_BASE, ram_addr=DST_BASE, ram_wr_data=0.
- idx is a registered word counter of width clog2(COPY_WORDS+1).
- Addresses:
  - rom_addr = SRC_BASE + 4*idx; ram_addr = DST_BASE + 4*idx.
  - Both are mod 2^32; wrap-around is silent.
- States:
  - IDLE:
    - Next state is READ, or DONE directly if COPY_WORDS==0.
    - The first IDLE cycle follows the last cycle with rst=1.
  - READ:
    - rom_addr is driven for idx; ram_we=0.
    - Next state is WRITE unconditionally.
  - WRITE:
    - rom_addr is held at the same idx, so ROM data stays stable during stalls.
    - ram_we=1; ram_wr_data = rom_rd_data (combinational pass-through).
    - If ram_ready=0: stay in WRITE, with all outputs unchanged.
    - If ram_ready=1 and idx==COPY_WORDS-1: go to DONE and clear idx to 0.
    - If ram_ready=1 otherwise: idx = idx+1 and go to READ.
  - DONE:
    - cpu_rst=0, done=1, ram_we=0.
    - If reload=1: go to IDLE with idx=0; cpu_rst is reasserted in the next cycle.
- Latency:
  - With ram_ready tied high, DONE is entered 1+2*COPY_WORDS cycles after reset release.
  - Each word produces exactly one accepted write.
- reload is ignored in IDLE, READ and WRITE.
- rst asserted in any state returns every register to its reset value on the next edge. The copy then restarts from word 0. A partially written RAM is simply overwritten.
- rom_rd_data is never sampled or registered by this block outside WRITE.
- No write is ever issued to an address outside DST_BASE .. DST_BASE+4*(COPY_WORDS-1).

Optional Feature:
- Macro: BOOTROM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [31:0] with reset value 0.
  - On every accepted write, checksum = checksum + ram_wr_data (mod 2^32).
  - checksum clears to 0 on the IDLE->READ transition.
  - The value is stable and valid whenever done=1.
- Undefined: the port and the accumulator do not exist; all other behaviour is identical.

Test Plan:
- COPY_WORDS=4, ROM words 11,22,33,44, ram_ready=1, release reset:
  - Writes (0x0,11), (0x4,22), (0x8,33), (0xC,44) in cycles 2,4,6,8.
  - done=1 and cpu_rst=0 at cycle 9.
- Same setup, ram_ready=0 for 3 cycles during word 1:
  - ram_we, ram_addr=0x4 and ram_wr_data=22 hold for 4 cycles.
  - Exactly 4 accepted writes; done at cycle 12.
- COPY_WORDS=0: done=1 one cycle after reset release; ram_we never asserts.
- COPY_WORDS=4, rst pulsed for 1 cycle while in WRITE of word 2:
  - Restarts and writes 0x0..0xC again in order; done is reached once.
- In DONE, pulse reload:
  - cpu_rst=1 the next cycle; the full copy repeats.
  - reload pulsed while busy=1 has no effect.
- With BOOTROM_LOADER_CHECKSUM_EN defined and ROM 11,22,33,44: checksum=110 at done. After reload it reads 110 again.
